// File: rtl/dff_reset_enable_if.sv
// Data/enable/output bundle for dff_reset_enable.
// q_par exists only when DFF_RE_PARITY_EN is defined.
`timescale 1ns/1ps
interface dff_reset_enable_if #(
  parameter int WIDTH = 1
);
  logic             enable;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             q_valid;
`ifdef DFF_RE_PARITY_EN
  logic             q_par;

  modport master (output enable, d, input  q, q_valid, q_par);
  modport slave  (input  enable, d, output q, q_valid, q_par);
`else
  modport master (output enable, d, input  q, q_valid);
  modport slave  (input  enable, d, output q, q_valid);
`endif
endinterface

// File: rtl/dff_reset_enable.sv
// D register with async active-high reset, sync load enable and a loaded-since-reset flag.
// Optional registered even parity output when DFF_RE_PARITY_EN is defined.
`timescale 1ns/1ps
module dff_reset_enable #(
  parameter int             WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic              clk,
  input logic              rst,
  dff_reset_enable_if.slave bus
);
  logic [WIDTH-1:0] q_r;
  logic             vld_r;

  // Ternary feedback mux: an X enable merges d and q bitwise, so bits where
  // they agree stay known.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= RESET_VALUE;
      vld_r <= 1'b0;
    end else begin
      q_r   <= bus.enable ? bus.d : q_r;
      vld_r <= bus.enable ? 1'b1  : vld_r;
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = vld_r;

`ifdef DFF_RE_PARITY_EN
  logic par_r;

  // Parity is registered from d alongside q, not derived combinationally from q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_r <= ^RESET_VALUE;
    else     par_r <= bus.enable ? ^bus.d : par_r;
  end

  assign bus.q_par = par_r;
`endif
endmodule

// File: tb/tb_dff_reset_enable.sv
// Directed bench for dff_reset_enable: 1-bit default instance and an 8-bit A5-reset instance.
`timescale 1ns/1ps
module tb_dff_reset_enable;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  dff_reset_enable_if #(.WIDTH(1)) bus1 ();
  dff_reset_enable_if #(.WIDTH(8)) bus8 ();

  dff_reset_enable #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  dff_reset_enable #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full clock period; rising edge at +5, falling edge at +10.
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic chk8(input string tag, input logic [7:0] exp_q, input logic exp_v);
    chk({tag, "_q8"}, {24'd0, bus8.q}, {24'd0, exp_q});
    chk({tag, "_v8"}, {31'd0, bus8.q_valid}, {31'd0, exp_v});
`ifdef DFF_RE_PARITY_EN
    chk({tag, "_par8"}, {31'd0, bus8.q_par}, {31'd0, ^exp_q});
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus1.enable = 1'b0; bus1.d = 1'b0;
    bus8.enable = 1'b0; bus8.d = 8'h00;

    // reset state, no clock edge seen yet
    #2;
    chk("rst_q",  {31'd0, bus1.q},       32'd0);
    chk("rst_v",  {31'd0, bus1.q_valid}, 32'd0);
    chk8("rst", 8'hA5, 1'b0);

    // load with d equal to current q still sets q_valid
    rst = 1'b0; #2;
    bus1.enable = 1'b1; bus1.d = 1'b0;
    tick();
    chk("same_q", {31'd0, bus1.q},       32'd0);
    chk("same_v", {31'd0, bus1.q_valid}, 32'd1);

    // load 1 then 0
    bus1.d = 1'b1; bus8.enable = 1'b1; bus8.d = 8'h01;
    tick();
    chk("ld1_q", {31'd0, bus1.q},       32'd1);
    chk("ld1_v", {31'd0, bus1.q_valid}, 32'd1);
    chk8("ld01", 8'h01, 1'b1);
    bus1.d = 1'b0; bus8.d = 8'h3C;
    tick();
    chk("ld0_q", {31'd0, bus1.q}, 32'd0);
    chk8("ld3c", 8'h3C, 1'b1);
    bus1.d = 1'b1; bus8.d = 8'hFE;
    tick();
    chk("ld1b_q", {31'd0, bus1.q}, 32'd1);
    chk8("ldfe", 8'hFE, 1'b1);

    // hold for 5 edges with enable low and different d
    bus1.enable = 1'b0; bus1.d = 1'b0;
    bus8.enable = 1'b0; bus8.d = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d_q", i), {31'd0, bus1.q}, 32'd1);
    end
    chk8("hold", 8'hFE, 1'b1);

    // async reset with clk held low
    rst = 1'b1; #1;
    chk("arst_q", {31'd0, bus1.q},       32'd0);
    chk("arst_v", {31'd0, bus1.q_valid}, 32'd0);
    chk8("arst", 8'hA5, 1'b0);

    // mid-operation reset: get q=1, then reset across 2 edges with enable/d high
    #1 rst = 1'b0; #2;
    bus1.enable = 1'b1; bus1.d = 1'b1;
    tick();
    chk("pre_q", {31'd0, bus1.q}, 32'd1);
    #2 rst = 1'b1; #1;
    chk("mrst_q0", {31'd0, bus1.q}, 32'd0);
    bus8.enable = 1'b1; bus8.d = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("mrst_q%0d", i + 1), {31'd0, bus1.q},       32'd0);
      chk($sformatf("mrst_v%0d", i + 1), {31'd0, bus1.q_valid}, 32'd0);
    end
    chk8("mrst", 8'hA5, 1'b0);
    rst = 1'b0; #2;
    tick();
    chk("rel_q", {31'd0, bus1.q},       32'd1);
    chk("rel_v", {31'd0, bus1.q_valid}, 32'd1);
    chk8("rel", 8'h5A, 1'b1);

    // falling-edge immunity: d toggles only while clk is high
    #5 clk = 1'b1;
    #1 bus1.d = 1'b0;
    #1 chk("fe_hi_q", {31'd0, bus1.q}, 32'd1);
    #3 clk = 1'b0;
    #1 chk("fe_lo_q", {31'd0, bus1.q}, 32'd1);
    #4 clk = 1'b1;
    #1 chk("fe_re_q", {31'd0, bus1.q}, 32'd0);
    bus1.d = 1'b1;
    #4 clk = 1'b0;
    #1 chk("fe_lo2_q", {31'd0, bus1.q}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
